// File: rtl/calc_entry_fsm_if.sv
// Keypad calculator bus: key strobe in, display/result status out.
//   key, key_valid        : decoded key code and one-cycle press strobe
//   state                 : current controller state code
//   disp_bcd/mask/neg     : 2*DIGITS-digit BCD display, lit mask, minus sign
//   result/result_neg     : registered result magnitude and sign
//   result_valid, err     : high while showing a result / while in error
// master = key source / display consumer, slave = calculator controller.
interface calc_entry_fsm_if #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned RW     = 14
);
  logic [7:0]          key;
  logic                key_valid;
  logic [2:0]          state;
  logic [8*DIGITS-1:0] disp_bcd;
  logic [2*DIGITS-1:0] disp_mask;
  logic                disp_neg;
  logic [RW-1:0]       result;
  logic                result_neg;
  logic                result_valid;
  logic                err;

  modport master (
    output key, key_valid,
    input  state, disp_bcd, disp_mask, disp_neg,
           result, result_neg, result_valid, err
  );

  modport slave (
    input  key, key_valid,
    output state, disp_bcd, disp_mask, disp_neg,
           result, result_neg, result_valid, err
  );
endinterface

// File: rtl/calc_entry_fsm.sv
// Keypad calculator controller. Builds two DIGITS-wide decimal operands
// and an operator from key presses, computes add/sub/mul, and drives a
// 2*DIGITS-digit BCD display. Supports backspace, operator change,
// chaining a result into the next operation and an error state.
//   press_clk : key-domain clock
//   rst       : asynchronous, active-high reset
//   bus       : calc_entry_fsm_if slave (key input, display/result output)
module calc_entry_fsm #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned RW     = 14
) (
  input logic            press_clk,
  input logic            rst,
  calc_entry_fsm_if.slave bus
);
  localparam int unsigned AW = 4 * DIGITS;
  localparam int unsigned DW = 8 * DIGITS;
  localparam int unsigned ND = 2 * DIGITS;
  localparam int unsigned CW = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTER_A = 3'd1,
    OP      = 3'd2,
    ENTER_B = 3'd3,
    CALC    = 3'd4,
    SHOW    = 3'd5,
    ERR     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam logic [RW-1:0] OPERAND_MAX = RW'(pow10(DIGITS) - 1);

  function automatic logic [RW-1:0] bcd_to_bin(input logic [AW-1:0] v);
    logic [RW-1:0] acc;
    acc = '0;
    for (int unsigned i = DIGITS; i > 0; i--)
      acc = RW'(acc * RW'(10)) + RW'(v[4*(i-1) +: 4]);
    return acc;
  endfunction

  // Double dabble across all 2*DIGITS display digits.
  function automatic logic [DW-1:0] bin_to_bcd(input logic [RW-1:0] v);
    logic [DW-1:0] d;
    d = '0;
    for (int unsigned b = 0; b < RW; b++) begin
      for (int unsigned n = 0; n < ND; n++)
        if (d[4*n +: 4] >= 4'd5) d[4*n +: 4] = d[4*n +: 4] + 4'd3;
      d = {d[DW-2:0], v[RW-1-b]};
    end
    return d;
  endfunction

  // Lit mask with leading zeros blanked; digit 0 always lit.
  function automatic logic [ND-1:0] lead_mask(input logic [DW-1:0] d);
    logic [ND-1:0] m;
    logic          seen;
    m    = '0;
    seen = 1'b0;
    for (int unsigned n = ND; n > 0; n--) begin
      seen     = seen | (d[4*(n-1) +: 4] != 4'd0);
      m[n-1]   = seen;
    end
    m[0] = 1'b1;
    return m;
  endfunction

  function automatic logic [ND-1:0] count_mask(input logic [CW-1:0] c);
    logic [ND-1:0] m;
    m = '0;
    for (int unsigned n = 0; n < ND; n++) m[n] = (n < 32'(c));
    return m;
  endfunction

  state_t        st, st_n;
  op_t           op_q, op_n;
  logic [AW-1:0] a, a_n, b, b_n;
  logic [CW-1:0] cnt_a, cnt_a_n, cnt_b, cnt_b_n;
  logic [RW-1:0] res, res_n;
  logic          neg, neg_n;

  logic [RW-1:0] a_bin, b_bin;
  logic [DW-1:0] res_bcd;
  logic [ND-1:0] res_lead;

  logic       k_dig, k_op, k_eq, k_bs, k_clr;
  logic [3:0] k_val;

  assign a_bin    = bcd_to_bin(a);
  assign b_bin    = bcd_to_bin(b);
  assign res_bcd  = bin_to_bcd(res);
  assign res_lead = lead_mask(res_bcd);

  assign k_val = bus.key[3:0];
  assign k_dig = bus.key_valid && !bus.key[7] && (bus.key[3:0] <= 4'd9);
  assign k_op  = bus.key_valid && (bus.key[7:4] == 4'hF) && (bus.key[3:0] <= 4'd2);
  assign k_eq  = bus.key_valid && (bus.key == 8'hE0);
  assign k_bs  = bus.key_valid && (bus.key == 8'hB0);
  assign k_clr = bus.key_valid && (bus.key == 8'hC0);

  always_ff @(posedge press_clk or posedge rst) begin
    if (rst) begin
      st    <= IDLE;
      op_q  <= OP_ADD;
      a     <= '0;
      b     <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      res   <= '0;
      neg   <= 1'b0;
    end else begin
      st    <= st_n;
      op_q  <= op_n;
      a     <= a_n;
      b     <= b_n;
      cnt_a <= cnt_a_n;
      cnt_b <= cnt_b_n;
      res   <= res_n;
      neg   <= neg_n;
    end
  end

  always_comb begin
    st_n    = st;
    op_n    = op_q;
    a_n     = a;
    b_n     = b;
    cnt_a_n = cnt_a;
    cnt_b_n = cnt_b;
    res_n   = res;
    neg_n   = neg;
    if (k_clr) begin
      st_n    = IDLE;
      op_n    = OP_ADD;
      a_n     = '0;
      b_n     = '0;
      cnt_a_n = '0;
      cnt_b_n = '0;
      res_n   = '0;
      neg_n   = 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (k_dig) begin
            a_n     = AW'(k_val);
            cnt_a_n = CW'(1);
            st_n    = ENTER_A;
          end
        end
        ENTER_A: begin
          if (k_dig) begin
            if (cnt_a < CW'(DIGITS)) begin
              a_n       = a << 4;
              a_n[3:0]  = k_val;
              cnt_a_n   = cnt_a + CW'(1);
            end
          end else if (k_bs) begin
            a_n     = a >> 4;
            cnt_a_n = cnt_a - CW'(1);
            if (cnt_a == CW'(1)) st_n = IDLE;
          end else if (k_op) begin
            op_n = op_t'(bus.key[1:0]);
            st_n = OP;
          end
        end
        OP: begin
          if (k_op) begin
            op_n = op_t'(bus.key[1:0]);
          end else if (k_dig) begin
            b_n     = AW'(k_val);
            cnt_b_n = CW'(1);
            st_n    = ENTER_B;
          end else if (k_bs) begin
            st_n = ENTER_A;
          end
        end
        ENTER_B: begin
          if (k_dig) begin
            if (cnt_b < CW'(DIGITS)) begin
              b_n       = b << 4;
              b_n[3:0]  = k_val;
              cnt_b_n   = cnt_b + CW'(1);
            end
          end else if (k_bs) begin
            b_n     = b >> 4;
            cnt_b_n = cnt_b - CW'(1);
            if (cnt_b == CW'(1)) st_n = OP;
          end else if (k_eq) begin
            st_n = CALC;
          end
        end
        CALC: begin
          unique case (op_q)
            OP_SUB: begin
              neg_n = (a_bin < b_bin);
              res_n = (a_bin < b_bin) ? (b_bin - a_bin) : (a_bin - b_bin);
            end
            OP_MUL: begin
              neg_n = 1'b0;
              res_n = a_bin * b_bin;
            end
            default: begin
              neg_n = 1'b0;
              res_n = a_bin + b_bin;
            end
          endcase
          st_n = SHOW;
        end
        SHOW: begin
          if (k_dig) begin
            a_n     = AW'(k_val);
            cnt_a_n = CW'(1);
            b_n     = '0;
            cnt_b_n = '0;
            st_n    = ENTER_A;
          end else if (k_op) begin
            // Chain only a non-negative result that fits an operand;
            // its significant digit count comes from the display mask.
            if (!neg && (res <= OPERAND_MAX)) begin
              a_n     = res_bcd[AW-1:0];
              cnt_a_n = CW'($countones(res_lead[DIGITS-1:0]));
              op_n    = op_t'(bus.key[1:0]);
              st_n    = OP;
            end else begin
              st_n = ERR;
            end
          end
        end
        ERR: begin
          st_n = ERR;
        end
        default: begin
          st_n = IDLE;
        end
      endcase
    end
  end

  logic [DW-1:0] disp_raw, disp_bcd_c;
  logic [ND-1:0] disp_mask_c;
  logic          disp_neg_c;

  always_comb begin
    disp_raw    = '0;
    disp_mask_c = '0;
    disp_neg_c  = 1'b0;
    disp_bcd_c  = '0;
    unique case (st)
      ENTER_A, OP: begin
        disp_raw    = DW'(a);
        disp_mask_c = count_mask(cnt_a);
      end
      ENTER_B: begin
        disp_raw    = DW'(b);
        disp_mask_c = count_mask(cnt_b);
      end
      SHOW: begin
        disp_raw    = res_bcd;
        disp_mask_c = res_lead;
        disp_neg_c  = neg;
      end
      default: begin
        disp_raw = '0;
      end
    endcase
    for (int unsigned n = 0; n < ND; n++)
      disp_bcd_c[4*n +: 4] = disp_mask_c[n] ? disp_raw[4*n +: 4] : 4'd0;
  end

  assign bus.state        = st;
  assign bus.disp_bcd     = disp_bcd_c;
  assign bus.disp_mask    = disp_mask_c;
  assign bus.disp_neg     = disp_neg_c;
  assign bus.result       = res;
  assign bus.result_neg   = neg;
  assign bus.result_valid = (st == SHOW);
  assign bus.err          = (st == ERR);
endmodule

// File: tb/tb_calc_entry_fsm.sv
// Directed bench for calc_entry_fsm (DIGITS=2, RW=14). Expected results
// are queued when the equal key is driven and popped when SHOW appears.
module tb_calc_entry_fsm;
  logic press_clk = 1'b0;
  logic rst;

  always #5 press_clk = ~press_clk;

  calc_entry_fsm_if #(.DIGITS(2), .RW(14)) bus();

  calc_entry_fsm #(.DIGITS(2), .RW(14)) dut (
    .press_clk(press_clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int res;
    int neg;
    int bcd;
    int mask;
  } exp_t;

  exp_t sb[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [7:0] k);
    @(negedge press_clk);
    bus.key       = k;
    bus.key_valid = 1'b1;
    @(negedge press_clk);
    bus.key_valid = 1'b0;
    bus.key       = 8'h00;
  endtask

  task automatic disp_chk(input string tag, input int st, input int bcd, input int mask);
    check({tag, "_state"}, 32'(bus.state), st);
    check({tag, "_bcd"},   32'(bus.disp_bcd), bcd);
    check({tag, "_mask"},  32'(bus.disp_mask), mask);
  endtask

  task automatic expect_result(input int res, input int neg, input int bcd, input int mask);
    exp_t e;
    e.res  = res;
    e.neg  = neg;
    e.bcd  = bcd;
    e.mask = mask;
    sb.push_back(e);
  endtask

  // Press equal, confirm the single CALC cycle, then compare SHOW against
  // the oldest queued expectation.
  task automatic equal_and_check(input string tag);
    int   n;
    exp_t e;
    press(8'hE0);
    check({tag, "_calc_state"}, 32'(bus.state), 4);
    n = 0;
    while (!bus.result_valid && n < 8) begin
      @(negedge press_clk);
      n++;
    end
    check({tag, "_calc_latency"}, n, 1);
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_result"},     32'(bus.result), e.res);
      check({tag, "_result_neg"}, 32'(bus.result_neg), e.neg);
      check({tag, "_disp_neg"},   32'(bus.disp_neg), e.neg);
      disp_chk(tag, 5, e.bcd, e.mask);
      check({tag, "_valid"},      32'(bus.result_valid), 1);
      check({tag, "_err"},        32'(bus.err), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.key       = 8'h00;
    bus.key_valid = 1'b0;
    #12;
    disp_chk("reset", 0, 0, 0);
    check("reset_result", 32'(bus.result), 0);
    check("reset_valid",  32'(bus.result_valid), 0);
    check("reset_err",    32'(bus.err), 0);
    rst = 1'b0;

    // 12 + 34
    press(8'h01); press(8'h02); press(8'hF0); press(8'h03); press(8'h04);
    disp_chk("add_b", 3, 'h34, 'b0011);
    expect_result(46, 0, 'h0046, 'b0011);
    equal_and_check("add");

    // 05 - 12, new entry started from SHOW
    press(8'h00);
    disp_chk("sub_a0", 1, 'h0000, 'b0001);
    press(8'h05);
    disp_chk("sub_a1", 1, 'h0005, 'b0011);
    press(8'hF1); press(8'h01); press(8'h02);
    expect_result(7, 1, 'h0007, 'b0001);
    equal_and_check("sub");

    // 99 * 99
    press(8'h09); press(8'h09); press(8'hF2); press(8'h09); press(8'h09);
    expect_result(9801, 0, 'h9801, 'b1111);
    equal_and_check("mul");

    // Entry editing
    press(8'hC0);
    disp_chk("clr", 0, 0, 0);
    press(8'h01); press(8'h02); press(8'h03);
    disp_chk("full_a", 1, 'h0012, 'b0011);
    press(8'hB0);
    disp_chk("bs_a", 1, 'h0001, 'b0001);
    press(8'h04);
    disp_chk("a14", 1, 'h0014, 'b0011);
    press(8'hE0);
    check("eq_in_a", 32'(bus.state), 1);
    press(8'hB0); press(8'hB0);
    disp_chk("bs_idle", 0, 0, 0);
    press(8'h05); press(8'hF0);
    disp_chk("op", 2, 'h0005, 'b0001);
    press(8'hB0);
    disp_chk("bs_op", 1, 'h0005, 'b0001);
    press(8'hF0); press(8'hF2);
    check("op_change", 32'(bus.state), 2);
    press(8'h03);
    disp_chk("b3", 3, 'h0003, 'b0001);
    expect_result(15, 0, 'h0015, 'b0011);
    equal_and_check("opchg");

    // Chaining: 12*3=36, then +4
    press(8'hC0);
    press(8'h01); press(8'h02); press(8'hF2); press(8'h03);
    expect_result(36, 0, 'h0036, 'b0011);
    equal_and_check("chain1");
    press(8'hF0);
    disp_chk("chain_a", 2, 'h0036, 'b0011);
    press(8'h04);
    press(8'hB0);
    disp_chk("bs_b_op", 2, 'h0036, 'b0011);
    press(8'h04);
    expect_result(40, 0, 'h0040, 'b0011);
    equal_and_check("chain2");

    // Asynchronous reset between clock edges
    press(8'h01); press(8'h02); press(8'hF0); press(8'h03);
    check("pre_rst_state", 32'(bus.state), 3);
    #2 rst = 1'b1;
    #1;
    disp_chk("async_rst", 0, 0, 0);
    check("async_rst_result", 32'(bus.result), 0);
    check("async_rst_neg",    32'(bus.disp_neg), 0);
    #1 rst = 1'b0;

    // Chaining an oversized result goes to ERR
    press(8'h09); press(8'h09); press(8'hF2); press(8'h02);
    expect_result(198, 0, 'h0198, 'b0111);
    equal_and_check("big");
    press(8'hF0);
    disp_chk("err", 6, 0, 0);
    check("err_flag",  32'(bus.err), 1);
    check("err_valid", 32'(bus.result_valid), 0);
    press(8'h05);
    check("err_sticky", 32'(bus.state), 6);
    press(8'hC0);
    disp_chk("err_clr", 0, 0, 0);
    check("err_clr_flag",   32'(bus.err), 0);
    check("err_clr_result", 32'(bus.result), 0);

    // Clear from ENTER_B
    press(8'h01); press(8'h02); press(8'hF0); press(8'h03);
    check("clr_b_pre", 32'(bus.state), 3);
    press(8'hC0);
    disp_chk("clr_b", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/calc_entry_fsm.md
Name: calc_entry_fsm

Overview:
- Parametrised keypad calculator controller, next generation of the two-digit entry FSM.
- Accepts decoded key codes and builds two DIGITS-wide decimal operands plus an operator, then computes add, subtract or multiply.
- Drives a 2*DIGITS-digit BCD display with a per-digit blank mask and a sign flag.
- New features: backspace, operator change before the second operand, chaining a result into the next operation, signed subtraction results, and an error state.

Parameters:
- DIGITS, 2, maximum decimal digits per operand (1..4).
- RW, 14, result magnitude width in bits; must hold (10^DIGITS-1)^2.

Ports:
- press_clk  input  1  key-domain clock.
- rst  input  1  reset; asynchronous, active-high.
- key  input  8  key code, sampled only when key_valid=1.
- key_valid  input  1  one-press_clk-cycle strobe per key press.
- state  output  3  current state code.
- disp_bcd  output  8*DIGITS  BCD digits, digit 0 in the low nibble.
- disp_mask  output  2*DIGITS  1 = digit lit.
- disp_neg  output  1  show minus sign.
- result  output  RW  registered result magnitude.
- result_neg  output  1  result is negative.
- result_valid  output  1  high while in SHOW.
- err  output  1  high while in ERR.

Behaviour:
- Reset is asynchronous, active-high, on rst; clock is press_clk. Every event samples on posedge press_clk qualified by key_valid.
- Reset forces state=IDLE. All operand registers, digit counts, op, result, result_neg, result_valid and err go to 0.
- Key codes:
  - digit: key[7]=0, value key[3:0] in 0..9; key[7]=0 with key[3:0]>9 is ignored.
  - operators: 8'hF0 add, 8'hF1 sub, 8'hF2 mul; other 8'hFx ignored.
  - 8'hE0 equal, 8'hB0 backspace, 8'hC0 clear; any other code is ignored.
- Clear, in any state, goes to IDLE and zeroes operands, counts, result and flags. Clear has priority over every other condition except rst.
- Operands are held as DIGITS BCD nibbles with counts cnt_a and cnt_b (0..DIGITS).
  - A digit shifts in at the low nibble.
  - A digit arriving when the count is DIGITS is ignored.
  - Backspace shifts right and decrements the count.
- State codes: IDLE=0, ENTER_A=1, OP=2, ENTER_B=3, CALC=4, SHOW=5, ERR=6.
- IDLE:
  - digit: A=digit, cnt_a=1, go to ENTER_A.
  - operator, equal, backspace: ignored.
- ENTER_A:
  - digit: shift into A.
  - backspace: drop a digit; if cnt_a becomes 0, go to IDLE.
  - operator: latch op, go to OP.
  - equal: ignored.
- OP:
  - operator: replaces op.
  - digit: B=digit, cnt_b=1, go to ENTER_B.
  - backspace: go to ENTER_A with A unchanged.
  - equal: ignored.
- ENTER_B:
  - digit: shift into B.
  - backspace: drop a digit; if cnt_b becomes 0, go to OP.
  - equal: go to CALC.
  - operator: ignored.
- CALC lasts one cycle and ignores keys. It converts both BCD operands to binary and registers result and result_neg, then goes to SHOW.
  - add: A+B.
  - sub: |A-B|, with result_neg=(A<B).
  - mul: A*B.
  - result_valid rises on the first SHOW cycle.
- SHOW:
  - digit: start a new entry; A=digit, cnt_a=1, B cleared, result_valid=0, go to ENTER_A.
  - operator, chaining: if result_neg=0 and result<=10^DIGITS-1, load A=BCD(result) with cnt_a = its significant digit count (minimum 1), latch op, go to OP. Otherwise go to ERR.
  - equal, backspace: ignored.
- ERR: only clear or rst leaves it; err=1, display fully blank.
- Display is a combinational decode of the registered state, so it is valid in the same cycle as state.
  - IDLE: mask all 0, disp_neg=0.
  - ENTER_A: show A, mask low cnt_a digits.
  - OP: show A, mask low cnt_a digits.
  - ENTER_B: show B, mask low cnt_b digits.
  - CALC: all blank.
  - SHOW: show BCD(result) across 2*DIGITS digits with leading zeros blanked; digit 0 is always lit; disp_neg=result_neg.
  - Unlit nibbles read 0.
- Width rules: the result never exceeds RW bits for DIGITS operands. BCD conversion covers 2*DIGITS digits.

Test Plan (DIGITS=2, RW=14):
- Keys 1,2,F0,3,4,E0 -> 1 cycle in CALC, then SHOW with result=46, disp_bcd=16'h0046, disp_mask=4'b0011, result_valid=1.
- Keys 0,5,F1,1,2,E0 -> result=7, result_neg=1, disp_neg=1, disp_mask=4'b0001. Keys 9,9,F2,9,9,E0 -> result=9801, disp_mask=4'b1111.
- Keys 1,2,3,B0,4 -> 3 ignored, backspace leaves A=1, then A=14, cnt_a=2. Next B0,B0 -> IDLE. Next 5,F0,B0 -> ENTER_A with A=5. Next F0,F2 -> op=mul.
- Keys 1,2,F2,3,E0 (result 36), then F0,4,E0 -> A=36, result=40. Keys 9,9,F2,2,E0, then F0 -> ERR (198>99), err=1; then C0 -> IDLE, err=0.
- Keys 1,2,F0,3, then rst pulsed between press_clk edges -> state=0 immediately with all outputs 0. Then C0 in ENTER_B on a fresh sequence -> IDLE with mask 0.
